// File: rtl/timer_controller.sv
// Button-driven sequencer for the countdown timer: edit / run / pause / ring
// state machine with up-button auto-repeat, buzzer drive and field blink.
//
// state | meaning
// EDIT  | timer stopped, select/up edit the current field, blink active
// RUN   | timer counting down
// PAUSE | timer stopped, value held, no edits
// RING  | timer expired, buzzer on until a button edge or ring timeout
module timer_controller #(
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100,
  parameter int unsigned BLINK_CYCLES  = 250,
  parameter int unsigned RING_CYCLES   = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_select,
  input  logic       btn_up,
  input  logic       timer_out,
  input  logic       timer_zero,
  output logic       timer_enable,
  output logic [1:0] timer_select,
  output logic       timer_increment,
  output logic       buzzer,
  output logic       blink,
  output logic [1:0] state
);

  localparam logic [1:0] SELECT_SEC  = 2'd0;
  localparam logic [1:0] SELECT_MIN  = 2'd1;
  localparam logic [1:0] SELECT_HOUR = 2'd2;

  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0] HOLD_TC   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_TC = 32'(HOLD_CYCLES + REPEAT_CYCLES - 1);
  localparam logic [31:0] BLINK_TC  = 32'(BLINK_CYCLES - 1);
  localparam logic [31:0] RING_LIM  = 32'(RING_CYCLES);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    RING  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  select_d;
  logic        inc_req;
  logic        prev_start, prev_select, prev_up;
  logic        start_edge, select_edge, up_edge;
  logic [31:0] hold_cnt, ring_cnt, blink_cnt, ring_inc;
  logic        hold_active, repeat_hit, ring_done;

  assign start_edge  = btn_start  & ~prev_start;
  assign select_edge = btn_select & ~prev_select;
  assign up_edge     = btn_up     & ~prev_up;

  // Auto-repeat is armed only by a real up edge, so a button held through
  // reset or carried into EDIT never repeats on its own.
  assign repeat_hit = hold_active & btn_up & ((hold_cnt == HOLD_TC) || (hold_cnt == REPEAT_TC));
  assign ring_inc   = (ring_cnt == CNT_MAX) ? CNT_MAX : ring_cnt + 32'd1;
  assign ring_done  = ring_inc >= RING_LIM;

  always_comb begin
    state_d  = state_q;
    select_d = timer_select;
    inc_req  = 1'b0;
    case (state_q)
      EDIT: begin
        if (start_edge && !timer_zero) state_d = RUN;
        else if (select_edge) begin
          case (timer_select)
            SELECT_SEC: select_d = SELECT_MIN;
            SELECT_MIN: select_d = SELECT_HOUR;
            default:    select_d = SELECT_SEC;
          endcase
        end
        else if (up_edge || repeat_hit) inc_req = 1'b1;
      end
      RUN: begin
        if (timer_out) state_d = RING;
        else if (start_edge) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_edge && !timer_zero) state_d = RUN;
        else if (select_edge) state_d = EDIT;
      end
      RING: begin
        if (start_edge || select_edge || up_edge || ring_done) state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= EDIT;
      timer_select    <= SELECT_SEC;
      timer_enable    <= 1'b0;
      timer_increment <= 1'b0;
      buzzer          <= 1'b0;
      blink           <= 1'b1;
      prev_start      <= 1'b1;
      prev_select     <= 1'b1;
      prev_up         <= 1'b1;
      hold_cnt        <= '0;
      hold_active     <= 1'b0;
      ring_cnt        <= '0;
      blink_cnt       <= '0;
    end else begin
      state_q         <= state_d;
      timer_select    <= select_d;
      timer_enable    <= (state_d == RUN) || (state_d == RING);
      buzzer          <= (state_d == RING);
      // Never two strobes back to back: the timer needs a low cycle between.
      timer_increment <= inc_req & ~timer_increment;
      prev_start      <= btn_start;
      prev_select     <= btn_select;
      prev_up         <= btn_up;

      if (state_q == EDIT && state_d == EDIT && up_edge) begin
        hold_cnt    <= '0;
        hold_active <= 1'b1;
      end else if (hold_active && btn_up && state_d == EDIT) begin
        if (hold_cnt == REPEAT_TC) hold_cnt <= 32'(HOLD_CYCLES);
        else if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 32'd1;
      end else begin
        hold_cnt    <= '0;
        hold_active <= 1'b0;
      end

      if (state_q == RING && state_d == RING) ring_cnt <= ring_inc;
      else ring_cnt <= '0;

      if (state_d != EDIT) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state_q != EDIT || select_edge) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_TC) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller: vector table for single-cycle
// behaviour plus sequences for auto-repeat, ring timeout and reset.
module tb_timer_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_select, btn_up, timer_out, timer_zero;
  logic       timer_enable, timer_increment, buzzer, blink;
  logic [1:0] timer_select, state;

  int errors = 0;
  int checks = 0;

  timer_controller #(
    .HOLD_CYCLES(500), .REPEAT_CYCLES(100), .BLINK_CYCLES(4), .RING_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_select(btn_select),
    .btn_up(btn_up), .timer_out(timer_out), .timer_zero(timer_zero),
    .timer_enable(timer_enable), .timer_select(timer_select),
    .timer_increment(timer_increment), .buzzer(buzzer), .blink(blink), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, se, up, to, tz;
    logic [1:0] e_state;
    logic e_en;
    logic [1:0] e_sel;
    logic e_inc, e_buz, chk_blink, e_blink;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic st, logic se, logic up, logic to, logic tz,
                              logic [1:0] es, logic en, logic [1:0] sel,
                              logic inc, logic buz, logic cb, logic eb);
    vec_t v;
    v.st = st; v.se = se; v.up = up; v.to = to; v.tz = tz;
    v.e_state = es; v.e_en = en; v.e_sel = sel; v.e_inc = inc; v.e_buz = buz;
    v.chk_blink = cb; v.e_blink = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " state"}, 32'(state), 0);
    chk({tag, " enable"}, 32'(timer_enable), 0);
    chk({tag, " select"}, 32'(timer_select), 0);
    chk({tag, " increment"}, 32'(timer_increment), 0);
    chk({tag, " buzzer"}, 32'(buzzer), 0);
    chk({tag, " blink"}, 32'(blink), 1);
  endtask

  task automatic enter_ring();
    btn_start = 1'b1; tick();
    btn_start = 1'b0; tick();
    chk("pre-ring run", 32'(state), 1);
    timer_out = 1'b1; tick();
    chk("ring entry state", 32'(state), 3);
    chk("ring entry buzzer", 32'(buzzer), 1);
  endtask

  initial begin
    int pulses;
    int pos[8];
    int exp_pos[4] = '{0, 500, 600, 700};

    //             st se up to tz  state en sel inc buz cb eb
    vecs[0]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 1);
    vecs[6]  = mk(0, 1, 0, 0, 0,  0, 0, 2, 0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0);
    vecs[12] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    vecs[18] = mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 1, 0,  3, 1, 0, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 0,  3, 1, 0, 0, 1, 1, 0);
    vecs[22] = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1; btn_start = 1'b0; btn_select = 1'b0; btn_up = 1'b1;
    timer_out = 1'b0; timer_zero = 1'b0;
    #1;
    tick(); tick();
    chk_reset_values("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      btn_start = vecs[i].st; btn_select = vecs[i].se; btn_up = vecs[i].up;
      timer_out = vecs[i].to; timer_zero = vecs[i].tz;
      tick();
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d enable", i), 32'(timer_enable), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d select", i), 32'(timer_select), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d increment", i), 32'(timer_increment), 32'(vecs[i].e_inc));
      chk($sformatf("vec%0d buzzer", i), 32'(buzzer), 32'(vecs[i].e_buz));
      if (vecs[i].chk_blink) chk($sformatf("vec%0d blink", i), 32'(blink), 32'(vecs[i].e_blink));
    end

    // Auto-repeat: hold up for 800 cycles.
    pulses = 0;
    for (int i = 0; i < 8; i++) pos[i] = -1;
    btn_up = 1'b1;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (timer_increment) begin
        if (pulses < 8) pos[pulses] = k;
        pulses++;
      end
    end
    btn_up = 1'b0;
    tick();
    chk("repeat pulse count", 32'(pulses), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("repeat pulse%0d offset", i), 32'(pos[i]), 32'(exp_pos[i]));
    chk("repeat after release", 32'(timer_increment), 0);

    // Ring timeout after exactly 20 cycles.
    enter_ring();
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("ring timeout k%0d state", k), 32'(state), (k < 20) ? 3 : 0);
      chk($sformatf("ring timeout k%0d buzzer", k), 32'(buzzer), (k < 20) ? 1 : 0);
      chk($sformatf("ring timeout k%0d enable", k), 32'(timer_enable), (k < 20) ? 1 : 0);
    end
    timer_out = 1'b0;
    tick();

    // Ring cut short by an up press on cycle 6, with no increment.
    enter_ring();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("ring up k%0d state", k), 32'(state), 3);
    end
    btn_up = 1'b1;
    tick();
    chk("ring up exit state", 32'(state), 0);
    chk("ring up exit buzzer", 32'(buzzer), 0);
    chk("ring up exit enable", 32'(timer_enable), 0);
    chk("ring up exit increment", 32'(timer_increment), 0);
    timer_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ring up held k%0d increment", k), 32'(timer_increment), 0);
    end
    btn_up = 1'b0;
    tick();

    // Reset mid-RING with start and timer_out high.
    enter_ring();
    tick();
    reset = 1'b1; btn_start = 1'b1;
    tick();
    chk_reset_values("ring reset");
    reset = 1'b0; timer_out = 1'b0;
    tick();
    chk("held start after reset", 32'(state), 0);
    btn_start = 1'b0; tick();
    btn_start = 1'b1; tick();
    chk("start after release", 32'(state), 1);
    chk("start after release enable", 32'(timer_enable), 1);
    btn_start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
